// File: rtl/fetch_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue_if
//   Handshake bundle between the fetch stage, the prefetch queue and decode.
//   master : fetch/decode/hazard side (drives push, pop_ready, flush)
//   slave  : the prefetch queue itself
//   Signals:
//     push_valid, push_ready          fetch -> queue handshake
//     pc_plus_four_F, instruction_F   entry written on a push
//     pop_valid, pop_ready            queue -> decode handshake
//     pc_plus_four_D, instruction_D   head entry seen by decode
//     flush                           taken branch/jump from decode
//     count                           occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
interface fetch_prefetch_queue_if #(
    parameter int PTR_W = 2
);
    logic              push_valid;
    logic              push_ready;
    logic [31:0]       pc_plus_four_F;
    logic [31:0]       instruction_F;
    logic              pop_ready;
    logic              pop_valid;
    logic [31:0]       pc_plus_four_D;
    logic [31:0]       instruction_D;
    logic              flush;
    logic [PTR_W:0]    count;

    modport master (
        output push_valid, pc_plus_four_F, instruction_F, pop_ready, flush,
        input  push_ready, pop_valid, pc_plus_four_D, instruction_D, count
    );

    modport slave (
        input  push_valid, pc_plus_four_F, instruction_F, pop_ready, flush,
        output push_ready, pop_valid, pc_plus_four_D, instruction_D, count
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
//   Instruction prefetch FIFO between fetch and decode. Buffers
//   {pc_plus_four, instruction} pairs so fetch can run ahead while decode is
//   stalled; a taken branch/jump (flush) discards every entry.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-high; empties the queue immediately
//     fifo   fetch_prefetch_queue_if.slave (push/pop handshakes, flush, count)
//   Optional feature macro: PREFETCH_BYPASS_EN
//     When defined, an entry arriving at an empty queue is presented to
//     decode in the same cycle; if decode takes it, it is never written.
// ---------------------------------------------------------------------------
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    fetch_prefetch_queue_if.slave  fifo
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    // Storage is plain data and is intentionally left unreset.
    logic [31:0]     memPc    [DEPTH];
    logic [31:0]     memInstr [DEPTH];

    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;

    logic notEmpty;
    logic headValid;
    logic bypassHit;
    logic pushFire;
    logic memWrite;
    logic memPop;

    assign notEmpty = (count != '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypassHit = (count == '0) && fifo.push_valid && !fifo.flush;
`else
    assign bypassHit = 1'b0;
`endif

    assign headValid = (notEmpty && !fifo.flush) || bypassHit;
    assign pushFire  = fifo.push_valid && (count != FULL_CNT);

    // A bypassed entry taken by decode never touches storage. Storage pops
    // only happen from a non-empty queue, which excludes the bypass case.
    assign memWrite  = pushFire && !(bypassHit && fifo.pop_ready) && !fifo.flush;
    assign memPop    = notEmpty && fifo.pop_ready && !fifo.flush;

    assign fifo.push_ready = (count != FULL_CNT);
    assign fifo.pop_valid  = headValid;
    assign fifo.count      = count;

    always_comb begin
        fifo.pc_plus_four_D = 32'h0000_0000;
        fifo.instruction_D  = NOP_WORD;
        if (bypassHit) begin
            fifo.pc_plus_four_D = fifo.pc_plus_four_F;
            fifo.instruction_D  = fifo.instruction_F;
        end else if (headValid) begin
            fifo.pc_plus_four_D = memPc[rdPtr];
            fifo.instruction_D  = memInstr[rdPtr];
        end
    end

    always_ff @(posedge clock) begin
        if (memWrite) begin
            memPc[wrPtr]    <= fifo.pc_plus_four_F;
            memInstr[wrPtr] <= fifo.instruction_F;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; full/empty
    // come from count alone, never from pointer comparison.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (fifo.flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (memWrite) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (memPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({memWrite, memPop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
